// File: rtl/aespim_pkg.sv
// Shared types and constants for the AES/GHASH carry-less multiply path.
package aespim_pkg;

  localparam int CLMUL_CHUNK_W = 16;

  typedef enum logic [1:0] {CLMUL_IDLE, CLMUL_BUSY, CLMUL_DONE} clmul_seq_state_e;

  // Counter width for n chunks; a single chunk still needs one bit.
  function automatic int clmul_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/aespim_clmul16.sv
// Combinational 16x16 -> 32 carry-less multiply core (GF(2)[x] product).
module aespim_clmul16
  import aespim_pkg::*;
(
  input  logic [CLMUL_CHUNK_W-1:0]   a,
  input  logic [CLMUL_CHUNK_W-1:0]   b,
  output logic [2*CLMUL_CHUNK_W-1:0] p
);

  always_comb begin
    p = '0;
    for (int k = 0; k < CLMUL_CHUNK_W; k++) begin
      if (b[k]) p = p ^ ({{CLMUL_CHUNK_W{1'b0}}, a} << k);
    end
  end

endmodule

// File: rtl/aespim_clmul_seq.sv
// WIDTH x WIDTH carry-less multiply sequenced over one shared 16x16 core.
// Optional zero-chunk skipping of A is enabled by defining AESPIM_CLMUL_ZSKIP_EN.
module aespim_clmul_seq
  import aespim_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] res_o
);

  localparam int N  = WIDTH / CLMUL_CHUNK_W;
  localparam int CW = clmul_cnt_w(N);
  localparam int RW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  clmul_seq_state_e state_q, state_d;

  logic [WIDTH-1:0]         a_q, b_q;
  logic [CW-1:0]            i_q, j_q;
  logic [RW-1:0]            acc_q, res_q, acc_nxt, pp_shift;
  logic [CLMUL_CHUNK_W-1:0] a_chunk, b_chunk;
  logic [2*CLMUL_CHUNK_W-1:0] pp;
  logic [CW:0]              sh_idx;
  logic                     accept, skip, last;

  assign a_chunk = a_q[CLMUL_CHUNK_W*i_q +: CLMUL_CHUNK_W];
  assign b_chunk = b_q[CLMUL_CHUNK_W*j_q +: CLMUL_CHUNK_W];

  aespim_clmul16 u_core (
    .a (a_chunk),
    .b (b_chunk),
    .p (pp)
  );

  // Shift index i+j reaches 2N-2, so it needs one bit more than the counters.
  assign sh_idx   = {1'b0, i_q} + {1'b0, j_q};
  assign pp_shift = RW'(pp) << (32'(sh_idx) * CLMUL_CHUNK_W);
  assign acc_nxt  = skip ? acc_q : (acc_q ^ pp_shift);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    skip    = 1'b0;
    last    = 1'b0;
    case (state_q)
      CLMUL_IDLE: begin
        if (in_valid_i) begin
          accept  = 1'b1;
          state_d = CLMUL_BUSY;
        end
      end
      CLMUL_BUSY: begin
`ifdef AESPIM_CLMUL_ZSKIP_EN
        skip = (j_q == '0) && (a_chunk == '0);
`else
        skip = 1'b0;
`endif
        last = (i_q == LAST) && (skip || (j_q == LAST));
        if (last) state_d = CLMUL_DONE;
      end
      CLMUL_DONE: begin
        if (out_ready_i) state_d = CLMUL_IDLE;
      end
      default: state_d = CLMUL_IDLE;
    endcase
    // Flush overrides every transition, including a same-cycle accept.
    if (flush_i) begin
      state_d = CLMUL_IDLE;
      accept  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= CLMUL_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      i_q   <= '0;
      j_q   <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else if (flush_i) begin
      i_q   <= '0;
      j_q   <= '0;
      acc_q <= '0;
    end else if (accept) begin
      a_q   <= a_i;
      b_q   <= b_i;
      i_q   <= '0;
      j_q   <= '0;
      acc_q <= '0;
    end else if (state_q == CLMUL_BUSY) begin
      acc_q <= acc_nxt;
      if (last) begin
        res_q <= acc_nxt;
        i_q   <= '0;
        j_q   <= '0;
      end else if (skip || (j_q == LAST)) begin
        i_q <= i_q + 1'b1;
        j_q <= '0;
      end else begin
        j_q <= j_q + 1'b1;
      end
    end
  end

  assign in_ready_o  = (state_q == CLMUL_IDLE);
  assign out_valid_o = (state_q == CLMUL_DONE);
  assign res_o       = res_q;

endmodule

// File: tb/tb_aespim_clmul_seq.sv
// Directed bench for aespim_clmul_seq at WIDTH=32 (latency model follows AESPIM_CLMUL_ZSKIP_EN).
module tb_aespim_clmul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] a, b;
  logic [63:0] res;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  aespim_clmul_seq #(.WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .res_o       (res)
  );

  function automatic logic [63:0] clmul_ref(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) if (x[k]) r = r ^ ({32'b0, y} << k);
    return r;
  endfunction

  function automatic int exp_lat(input logic [31:0] x);
`ifdef AESPIM_CLMUL_ZSKIP_EN
    int l;
    l = 0;
    for (int c = 0; c < 2; c++) l += (x[16*c +: 16] == 16'h0) ? 1 : 2;
    return l;
`else
    return 4;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one op for a single cycle, then wait (bounded) for out_valid.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, output int lat);
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic full_op(input string tag, input logic [31:0] x, input logic [31:0] y);
    int lat;
    run_op(x, y, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat(x)));
    check({tag, "_res"}, res, clmul_ref(x, y));
    handshake();
    check({tag, "_idle"}, {62'b0, in_ready, out_valid}, 64'h2);
  endtask

  initial begin
    int lat;
    int seen;
    logic [63:0] held;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(in_ready), 64'h1);
    check("reset_valid", 64'(out_valid), 64'h0);
    check("reset_res", res, 64'h0);
    rst_n = 1'b1;

    // Basic products and the top-bit boundary
    full_op("t1_3x3", 32'h0000_0003, 32'h0000_0003);
    check("t1_const", res, 64'h0000_0000_0000_0005);
    full_op("t2_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("t2_ones_const", res, 64'h5555_5555_5555_5555);
    full_op("t2_msb", 32'h8000_0000, 32'h8000_0000);
    check("t2_msb_const", res, 64'h4000_0000_0000_0000);

    // Backpressure: result held, no new accept while DONE
    run_op(32'h0000_0005, 32'h0000_0003, lat);
    check("t3_res", res, 64'hF);
    in_valid = 1'b1; a = 32'h0000_0007; b = 32'h0000_0007;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t3_hold_res", res, 64'hF);
      check("t3_hold_flags", {62'b0, in_ready, out_valid}, 64'h1);
    end
    in_valid = 1'b0;
    handshake();
    check("t3_after_hs", {62'b0, in_ready, out_valid}, 64'h2);
    full_op("t3_next", 32'h0000_0007, 32'h0000_0007);
    check("t3_next_const", res, 64'h15);

    // Flush in second BUSY cycle
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t4_flush_idle", {62'b0, in_ready, out_valid}, 64'h2);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("t4_no_valid", 64'(seen), 64'h0);
    full_op("t4_next", 32'h0001_0000, 32'h0000_0001);
    check("t4_next_const", res, 64'h0000_0000_0001_0000);

    // Asynchronous reset mid-BUSY
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_res", res, 64'h0);
    check("t5_rst_flags", {62'b0, in_ready, out_valid}, 64'h2);
    @(negedge clk);
    rst_n = 1'b1;
    full_op("t6_zchunk", 32'h0000_0001, 32'h1234_5678);
    check("t6_const", res, 64'h0000_0000_1234_5678);

    // Flush together with out_ready in DONE: result not delivered, back to IDLE
    run_op(32'h0000_0003, 32'h0000_0005, lat);
    check("t7_valid", 64'(out_valid), 64'h1);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    check("t7_flags", {62'b0, in_ready, out_valid}, 64'h2);

    // Flush on the accept cycle drops the accept
    a = 32'h0000_0009; b = 32'h0000_0009; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("t8_dropped", {62'b0, in_ready, out_valid}, 64'h2);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("t8_no_valid", 64'(seen), 64'h0);

    // Random operands, mixing zero chunks
    for (int r = 0; r < 20; r++) begin
      logic [31:0] x, y;
      x = $urandom; y = $urandom;
      if (r % 4 == 1) x[31:16] = 16'h0;
      if (r % 4 == 2) x[15:0]  = 16'h0;
      full_op("rand", x, y);
    end

    held = 64'(n_fail);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
